// File: rtl/cci_mpf_svc_vtp_pt_fim_port.sv
// Memory-side responder for the VTP page-table walker: forwards walker reads and
// service-message writes to host memory, tracks credits, returns read data in order.
module cci_mpf_svc_vtp_pt_fim_port #(
  parameter int ADDR_WIDTH = 42,
  parameter int DATA_WIDTH = 512,
  parameter int MAX_RD_OUTSTANDING = 4,
  parameter int MAX_WR_OUTSTANDING = 4,
  localparam int RC_W = $clog2(MAX_RD_OUTSTANDING + 1),
  localparam int WC_W = $clog2(MAX_WR_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  readEn,
  input  logic [ADDR_WIDTH-1:0] readAddr,
  output logic                  readRdy,
  output logic                  readDataEn,
  output logic [DATA_WIDTH-1:0] readData,
  input  logic                  writeEn,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  output logic                  writeRdy,
  input  logic [63:0]           writeData,
  output logic                  mem_rd_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_rd_req_addr,
  input  logic                  mem_rd_req_ready,
  input  logic                  mem_rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rd_rsp_data,
  output logic                  mem_wr_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_wr_req_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_req_data,
  input  logic                  mem_wr_req_ready,
  input  logic                  mem_wr_rsp_valid,
  output logic [RC_W-1:0]       rd_outstanding,
  output logic [WC_W-1:0]       wr_outstanding
);

  localparam logic [RC_W-1:0] RD_MAX = RC_W'(MAX_RD_OUTSTANDING);
  localparam logic [WC_W-1:0] WR_MAX = WC_W'(MAX_WR_OUTSTANDING);

  typedef enum logic [1:0] {RD_IDLE, RD_BLOCKED, RD_ISSUE} rd_state_t;

  // Credit counters never wrap: callers only pass dec when the count is non-zero.
  function automatic logic [RC_W-1:0] rd_cnt_step(input logic [RC_W-1:0] cnt,
                                                  input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return cnt + RC_W'(1);
      2'b01:   return cnt - RC_W'(1);
      default: return cnt;
    endcase
  endfunction

  function automatic logic [WC_W-1:0] wr_cnt_step(input logic [WC_W-1:0] cnt,
                                                  input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return cnt + WC_W'(1);
      2'b01:   return cnt - WC_W'(1);
      default: return cnt;
    endcase
  endfunction

  logic                  wr_pend;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [WC_W-1:0]       wr_cnt;
  logic                  wr_accept;
  logic                  wr_ack;

  rd_state_t             rd_state, rd_state_n;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [RC_W-1:0]       rd_cnt;
  logic [WC_W-1:0]       wr_snap;
  logic                  snap_clear;
  logic                  rd_accept;
  logic                  rd_rsp;

  logic                  rsp_vld_p1;
  logic [DATA_WIDTH-1:0] rsp_data_p1;

  // Write path: single holding register
  assign writeRdy  = !wr_pend && (wr_cnt < WR_MAX);
  assign wr_accept = writeEn && writeRdy;
  assign wr_ack    = mem_wr_rsp_valid && (wr_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_pend <= 1'b0;
      wr_cnt  <= '0;
    end else begin
      if (wr_accept)
        wr_pend <= 1'b1;
      else if (wr_pend && mem_wr_req_ready)
        wr_pend <= 1'b0;
      wr_cnt <= wr_cnt_step(wr_cnt, wr_accept, wr_ack);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      wr_addr_q <= writeAddr;
      wr_data_q <= DATA_WIDTH'(writeData);
    end
  end

  assign mem_wr_req_valid = wr_pend;
  assign mem_wr_req_addr  = wr_addr_q;
  assign mem_wr_req_data  = wr_data_q;
  assign wr_outstanding   = wr_cnt;

  // Read path FSM
  assign rd_accept = readEn && readRdy;
  assign rd_rsp    = mem_rd_rsp_valid && (rd_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) rd_state <= RD_IDLE;
    else       rd_state <= rd_state_n;
  end

  // The read waits only for writes accepted before it; this cycle's ack counts.
  assign snap_clear = (wr_snap == '0) || ((wr_snap == WC_W'(1)) && wr_ack);

  always_comb begin
    rd_state_n = rd_state;
    unique case (rd_state)
      RD_IDLE:    if (rd_accept)        rd_state_n = RD_BLOCKED;
      RD_BLOCKED: if (snap_clear)       rd_state_n = RD_ISSUE;
      RD_ISSUE:   if (mem_rd_req_ready) rd_state_n = RD_IDLE;
      default:                          rd_state_n = RD_IDLE;
    endcase
  end

  always_comb begin
    readRdy          = (rd_state == RD_IDLE) && (rd_cnt < RD_MAX);
    mem_rd_req_valid = (rd_state == RD_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt  <= '0;
      wr_snap <= '0;
    end else begin
      rd_cnt <= rd_cnt_step(rd_cnt, rd_accept, rd_rsp);
      if (rd_accept)
        wr_snap <= wr_cnt - WC_W'(wr_ack);
      else if ((rd_state == RD_BLOCKED) && wr_ack && (wr_snap != '0))
        wr_snap <= wr_snap - WC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rd_accept) rd_addr_q <= readAddr;
  end

  assign mem_rd_req_addr = rd_addr_q;
  assign rd_outstanding  = rd_cnt;

  // Response stage p1: registered read data
  always_ff @(posedge clk) begin
    if (reset) rsp_vld_p1 <= 1'b0;
    else       rsp_vld_p1 <= rd_rsp;
  end

  always_ff @(posedge clk) begin
    if (rd_rsp) rsp_data_p1 <= mem_rd_rsp_data;
  end

  assign readDataEn = rsp_vld_p1;
  assign readData   = rsp_data_p1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(readEn && !readRdy)) else $error("readEn while readRdy low");
      assert (!(writeEn && !writeRdy)) else $error("writeEn while writeRdy low");
      assert (!(mem_rd_rsp_valid && (rd_cnt == '0)))
        else $warning("read response with no read outstanding dropped");
      assert (!(mem_wr_rsp_valid && (wr_cnt == '0)))
        else $warning("write ack with no write outstanding dropped");
    end
  end

endmodule
